// File: rtl/run_ctrl_if.sv
// Run-control bus: the core-side retire/store observation signals and restart
// going in, plus the run status, result and counters coming back out.
interface run_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             restart;
  logic             wb_valid;
  logic [31:0]      wb_instr;
  logic             st_valid;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;

  logic             core_rst;
  logic             running;
  logic             done;
  logic             pass;
  logic             timeout;
  logic [31:0]      exit_code;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] retire_cnt;

  // Harness side: drives the observation inputs, reads status.
  modport master (
    output restart, wb_valid, wb_instr, st_valid, st_addr, st_data,
    input  core_rst, running, done, pass, timeout, exit_code,
           cycle_cnt, retire_cnt
  );

  // Controller side.
  modport slave (
    input  restart, wb_valid, wb_instr, st_valid, st_addr, st_data,
    output core_rst, running, done, pass, timeout, exit_code,
           cycle_cnt, retire_cnt
  );
endinterface

// File: rtl/run_ctrl.sv
// Test-run controller: holds the core in reset for RST_CYCLES, lets it run
// while counting cycles and retires, and stops on a tohost store, an ECALL
// retire or a cycle timeout. Results stay sticky until restart or rst.
//
// state | meaning
// HOLD  | core_rst asserted, counting out the reset hold
// RUN   | core running, counters live, watching for halt causes
// DONE  | core held in reset, counters and result frozen, waiting for restart
module run_ctrl #(
  parameter int          RST_CYCLES  = 4,
  parameter int          TIMEOUT     = 250,
  parameter int          CNT_W       = 16,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
  parameter bit          ECALL_HALT  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  run_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {HOLD, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [7:0]       HOLD_LAST = 8'(RST_CYCLES - 1);
  localparam logic [31:0]      ECALL     = 32'h0000_0073;

  state_t           state;
  logic [7:0]       hold_cnt;
  logic             core_rst_r;
  logic             running_r;
  logic             done_r;
  logic             pass_r;
  logic             timeout_r;
  logic [31:0]      exit_code_r;
  logic [CNT_W-1:0] cycle_cnt_r;
  logic [CNT_W-1:0] retire_cnt_r;

  logic tohost_hit;
  logic ecall_hit;
  logic timeout_hit;

  // Halt-cause decode; only consulted while in RUN.
  always_comb begin
    tohost_hit  = bus.st_valid && (bus.st_addr == TOHOST_ADDR);
    ecall_hit   = ECALL_HALT && bus.wb_valid && (bus.wb_instr == ECALL);
    timeout_hit = (cycle_cnt_r == TO_LAST);
  end

  // Sequencer with registered outputs; tohost beats ECALL beats timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= HOLD;
      hold_cnt     <= '0;
      core_rst_r   <= 1'b1;
      running_r    <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      timeout_r    <= 1'b0;
      exit_code_r  <= '0;
      cycle_cnt_r  <= '0;
      retire_cnt_r <= '0;
    end else begin
      case (state)
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state      <= RUN;
            hold_cnt   <= '0;
            core_rst_r <= 1'b0;
            running_r  <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end

        RUN: begin
          // The retire on the halting cycle still counts.
          if (bus.wb_valid && (retire_cnt_r != CNT_MAX))
            retire_cnt_r <= retire_cnt_r + 1'b1;

          if (tohost_hit || ecall_hit || timeout_hit) begin
            state      <= DONE;
            core_rst_r <= 1'b1;
            running_r  <= 1'b0;
            done_r     <= 1'b1;
            if (tohost_hit) begin
              exit_code_r <= bus.st_data;
              pass_r      <= (bus.st_data == 32'd1);
            end else if (ecall_hit) begin
              exit_code_r <= 32'd0;
              pass_r      <= 1'b1;
            end else begin
              exit_code_r <= 32'hFFFF_FFFF;
              pass_r      <= 1'b0;
              timeout_r   <= 1'b1;
            end
          end else if (cycle_cnt_r != CNT_MAX) begin
            // cycle_cnt is left at the halting cycle's value.
            cycle_cnt_r <= cycle_cnt_r + 1'b1;
          end
        end

        DONE: begin
          if (bus.restart) begin
            state        <= HOLD;
            hold_cnt     <= '0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            timeout_r    <= 1'b0;
            exit_code_r  <= '0;
            cycle_cnt_r  <= '0;
            retire_cnt_r <= '0;
          end
        end

        default: begin
          state      <= HOLD;
          hold_cnt   <= '0;
          core_rst_r <= 1'b1;
          running_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.core_rst   = core_rst_r;
  assign bus.running    = running_r;
  assign bus.done       = done_r;
  assign bus.pass       = pass_r;
  assign bus.timeout    = timeout_r;
  assign bus.exit_code  = exit_code_r;
  assign bus.cycle_cnt  = cycle_cnt_r;
  assign bus.retire_cnt = retire_cnt_r;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: directed run scenarios; each expected run result is
// queued when the halting stimulus is issued, and a monitor compares it when
// done rises.
module tb_run_ctrl;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] TOHO  = 32'h0000_1000;

  typedef struct {
    logic        pass;
    logic        timeout;
    logic [31:0] exit_code;
    logic [15:0] cc;
    logic [15:0] rc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;

  run_ctrl_if #(.CNT_W(16)) bus_a ();
  run_ctrl_if #(.CNT_W(16)) bus_b ();

  run_ctrl u_a (.clk(clk), .rst(rst), .bus(bus_a));
  run_ctrl #(.TIMEOUT(30), .ECALL_HALT(1'b0)) u_b (.clk(clk), .rst(rst2), .bus(bus_b));

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic exp_t mk(input logic p, input logic t, input logic [31:0] e,
                              input logic [15:0] c, input logic [15:0] r);
    exp_t x;
    x.pass = p; x.timeout = t; x.exit_code = e; x.cc = c; x.rc = r;
    return x;
  endfunction

  // Monitors: on each done rising edge pop and compare the queued result.
  logic done_a_q = 1'b0;
  logic done_b_q = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (bus_a.done && !done_a_q) begin
      if (q_a.size() == 0) begin
        checks++;
        $display("FAIL a_unexpected_done: done rose with no expected result queued");
      end else begin
        e = q_a.pop_front();
        chk("a_pass",       32'(bus_a.pass),       32'(e.pass));
        chk("a_timeout",    32'(bus_a.timeout),    32'(e.timeout));
        chk("a_exit_code",  bus_a.exit_code,       e.exit_code);
        chk("a_cycle_cnt",  32'(bus_a.cycle_cnt),  32'(e.cc));
        chk("a_retire_cnt", 32'(bus_a.retire_cnt), 32'(e.rc));
      end
    end
    if (bus_b.done && !done_b_q) begin
      if (q_b.size() == 0) begin
        checks++;
        $display("FAIL b_unexpected_done: done rose with no expected result queued");
      end else begin
        e = q_b.pop_front();
        chk("b_pass",       32'(bus_b.pass),       32'(e.pass));
        chk("b_timeout",    32'(bus_b.timeout),    32'(e.timeout));
        chk("b_exit_code",  bus_b.exit_code,       e.exit_code);
        chk("b_cycle_cnt",  32'(bus_b.cycle_cnt),  32'(e.cc));
        chk("b_retire_cnt", 32'(bus_b.retire_cnt), 32'(e.rc));
      end
    end
    done_a_q = bus_a.done;
    done_b_q = bus_b.done;
  end

  task automatic idle_a();
    bus_a.restart = 0; bus_a.wb_valid = 0; bus_a.wb_instr = NOP;
    bus_a.st_valid = 0; bus_a.st_addr = 0; bus_a.st_data = 0;
  endtask

  // Drive one cycle's inputs on A and advance to the next falling edge.
  task automatic cyc_a(input logic wv, input logic [31:0] ins, input logic sv,
                       input logic [31:0] ad, input logic [31:0] dt);
    bus_a.wb_valid = wv; bus_a.wb_instr = ins;
    bus_a.st_valid = sv; bus_a.st_addr = ad; bus_a.st_data = dt;
    @(negedge clk);
    bus_a.restart = 0;
  endtask

  // Count falling edges with A still in hold until running appears.
  task automatic hold_len_a(input bit noise, output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus_a.restart = 0;
      if (bus_a.running) break;
      if (bus_a.core_rst) n++;
      if (noise) begin
        bus_a.wb_valid = 1; bus_a.wb_instr = ECALL;
        bus_a.st_valid = 1; bus_a.st_addr = TOHO; bus_a.st_data = 1;
      end
    end
    idle_a();
    chk("hold_len", 32'(n), 32'd4);
    chk("run_start_running", 32'(bus_a.running), 32'd1);
    chk("run_start_core_rst", 32'(bus_a.core_rst), 32'd0);
    chk("run_start_cycle_cnt", 32'(bus_a.cycle_cnt), 32'd0);
  endtask

  task automatic wait_done_a(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (bus_a.done) return;
      @(negedge clk);
    end
    checks++;
    $display("FAIL a_done_wait: done never rose within %0d cycles", budget);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    idle_a();
    bus_b.restart = 0; bus_b.wb_valid = 0; bus_b.wb_instr = NOP;
    bus_b.st_valid = 0; bus_b.st_addr = 0; bus_b.st_data = 0;
    repeat (3) @(negedge clk);

    // Reset values.
    chk("rst_core_rst",   32'(bus_a.core_rst),   32'd1);
    chk("rst_running",    32'(bus_a.running),    32'd0);
    chk("rst_done",       32'(bus_a.done),       32'd0);
    chk("rst_pass",       32'(bus_a.pass),       32'd0);
    chk("rst_timeout",    32'(bus_a.timeout),    32'd0);
    chk("rst_exit_code",  bus_a.exit_code,       32'd0);
    chk("rst_cycle_cnt",  32'(bus_a.cycle_cnt),  32'd0);
    chk("rst_retire_cnt", 32'(bus_a.retire_cnt), 32'd0);

    // Instance B: ECALL ignored, timeout at 30 cycles.
    @(posedge clk); #1 rst2 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_b.running) break;
    end
    chk("b_run_start", 32'(bus_b.running), 32'd1);
    q_b.push_back(mk(1'b0, 1'b1, 32'hFFFF_FFFF, 16'd29, 16'd30));
    k = -1;
    for (int i = 0; i < 40; i++) begin
      bus_b.wb_valid = 1; bus_b.wb_instr = ECALL;
      @(negedge clk);
      if (bus_b.done) begin k = i; break; end
    end
    bus_b.wb_valid = 0;
    chk("b_ecall_ignored_len", 32'(k), 32'd29);

    // A: release and count the hold.
    @(posedge clk); #1 rst = 0;
    hold_len_a(1'b0, n);

    // Run 1: 10 retires, tohost=1 at cycle 20, then activity in DONE.
    q_a.push_back(mk(1'b1, 1'b0, 32'd1, 16'd20, 16'd10));
    for (int c = 0; c < 20; c++) cyc_a(c < 10, NOP, 0, 0, 0);
    cyc_a(0, NOP, 1, TOHO, 32'd1);
    for (int c = 0; c < 5; c++) cyc_a(1, ECALL, 1, TOHO, 32'd5);
    idle_a();
    chk("done_sticky",      32'(bus_a.done),       32'd1);
    chk("done_running",     32'(bus_a.running),    32'd0);
    chk("done_core_rst",    32'(bus_a.core_rst),   32'd1);
    chk("done_retire_cnt",  32'(bus_a.retire_cnt), 32'd10);
    chk("done_cycle_cnt",   32'(bus_a.cycle_cnt),  32'd20);
    chk("done_exit_code",   bus_a.exit_code,       32'd1);

    // Run 2: restart, tohost/ECALL noise in HOLD ignored, restart in RUN
    // ignored, non-tohost store ignored, ECALL halt at cycle 12.
    bus_a.restart = 1;
    hold_len_a(1'b1, n);
    chk("restart_retire_cnt", 32'(bus_a.retire_cnt), 32'd0);
    chk("restart_done",       32'(bus_a.done),       32'd0);
    chk("restart_exit_code",  bus_a.exit_code,       32'd0);
    chk("restart_pass",       32'(bus_a.pass),       32'd0);
    q_a.push_back(mk(1'b1, 1'b0, 32'd0, 16'd12, 16'd13));
    for (int c = 0; c < 12; c++) begin
      if (c == 5) bus_a.restart = 1;
      cyc_a(1, NOP, c == 7, 32'h0000_1004, 32'd1);
    end
    cyc_a(1, ECALL, 0, 0, 0);
    cyc_a(0, NOP, 0, 0, 0);
    chk("ecall_done", 32'(bus_a.done), 32'd1);

    // Run 3: tohost 7 and ECALL in the same cycle; tohost wins.
    bus_a.restart = 1;
    hold_len_a(1'b0, n);
    q_a.push_back(mk(1'b0, 1'b0, 32'd7, 16'd3, 16'd1));
    for (int c = 0; c < 3; c++) cyc_a(0, NOP, 0, 0, 0);
    cyc_a(1, ECALL, 1, TOHO, 32'd7);
    cyc_a(0, NOP, 0, 0, 0);
    chk("prio_done", 32'(bus_a.done), 32'd1);

    // Run 4: no halt, timeout on cycle 249.
    bus_a.restart = 1;
    hold_len_a(1'b0, n);
    q_a.push_back(mk(1'b0, 1'b1, 32'hFFFF_FFFF, 16'd249, 16'd5));
    k = 0;
    for (int c = 0; c < 5; c++) begin cyc_a(1, NOP, 0, 0, 0); k++; end
    for (int c = 0; c < 300; c++) begin
      if (bus_a.done) break;
      cyc_a(0, NOP, 0, 0, 0);
      k++;
    end
    wait_done_a(2);
    chk("timeout_run_len", 32'(k), 32'd250);

    // Run 5: rst pulse at cycle 50 aborts immediately, then a full hold.
    bus_a.restart = 1;
    hold_len_a(1'b0, n);
    for (int c = 0; c < 50; c++) cyc_a(1, NOP, 0, 0, 0);
    rst = 1;
    idle_a();
    #1;
    chk("abort_core_rst",   32'(bus_a.core_rst),   32'd1);
    chk("abort_running",    32'(bus_a.running),    32'd0);
    chk("abort_cycle_cnt",  32'(bus_a.cycle_cnt),  32'd0);
    chk("abort_retire_cnt", 32'(bus_a.retire_cnt), 32'd0);
    chk("abort_done",       32'(bus_a.done),       32'd0);
    @(posedge clk); #1 rst = 0;
    hold_len_a(1'b0, n);
    q_a.push_back(mk(1'b0, 1'b0, 32'd2, 16'd2, 16'd0));
    cyc_a(0, NOP, 0, 0, 0);
    cyc_a(0, NOP, 0, 0, 0);
    cyc_a(0, NOP, 1, TOHO, 32'd2);
    cyc_a(0, NOP, 0, 0, 0);
    wait_done_a(5);

    repeat (3) @(negedge clk);
    chk("q_a_drained", 32'(q_a.size()), 32'd0);
    chk("q_b_drained", 32'(q_b.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 4: core reset hold length in clk cycles after rst release (range 1..255).
REQ-002 SHALL have parameter TIMEOUT, default 250: max RUN cycles before forced stop (range 1..2^CNT_W-1).
REQ-003 SHALL have parameter CNT_W, default 16: width of the cycle and retire counters.
REQ-004 SHALL have parameter TOHOST_ADDR, default 32'h0000_1000: store address that signals end of test.
REQ-005 SHALL have parameter ECALL_HALT, default 1: 1 means a retired ECALL (32'h0000_0073) also halts; 0 means it is ignored.
REQ-006 SHALL have ports: clk  in  1  single clock; all logic is on the rising edge.
REQ-007 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have ports: restart  in  1  one-cycle pulse; valid only in DONE.
REQ-009 SHALL have ports: wb_valid  in  1  an instruction retires this cycle.
REQ-010 SHALL have ports: wb_instr  in  32  encoding of the retiring instruction.
REQ-011 SHALL have ports: st_valid  in  1  a data-memory store occurs this cycle.
REQ-012 SHALL have ports: st_addr  in  32  and st_data  in  32  store address and data.
REQ-013 SHALL have outputs: core_rst 1 (active-high reset to the core), running 1, done 1, pass 1, timeout 1, exit_code 32, cycle_cnt CNT_W, retire_cnt CNT_W.

Function
REQ-014 SHALL implement the FSM states HOLD, RUN and DONE; all outputs are registered.
REQ-015 In HOLD, SHALL assert core_rst=1 and increment the hold counter each cycle; after exactly RST_CYCLES cycles in HOLD it SHALL go to RUN.
REQ-016 In RUN, SHALL drive core_rst=0 and running=1; cycle_cnt SHALL increment every cycle, starting from 0 on the first RUN cycle.
REQ-017 In RUN, retire_cnt SHALL increment on each cycle with wb_valid=1; both counters saturate at all-ones and do not wrap.
REQ-018 Tohost halt: when st_valid=1 and st_addr==TOHOST_ADDR in RUN, the block SHALL go to DONE next cycle with exit_code=st_data and pass=(st_data==32'd1).
REQ-019 ECALL halt (only when ECALL_HALT=1): when wb_valid=1 and wb_instr==32'h0000_0073 in RUN, the block SHALL go to DONE with exit_code=0 and pass=1.
REQ-020 Timeout: when cycle_cnt==TIMEOUT-1 in RUN and there is no halt that cycle, the block SHALL go to DONE with timeout=1, pass=0 and exit_code=32'hFFFF_FFFF.
REQ-021 Same-cycle priority SHALL be tohost, then ECALL, then timeout; only one cause is recorded.
REQ-022 The retire on the halting cycle SHALL still be counted; cycle_cnt SHALL stop after the halting cycle.
REQ-023 In DONE, SHALL hold done=1 and running=0, hold core_rst=1, and freeze all counters and results (sticky).
REQ-024 restart=1 in DONE SHALL clear counters, results and done, then enter HOLD; restart in HOLD or RUN SHALL be ignored.
REQ-025 st_valid and wb_valid in HOLD or DONE SHALL be ignored.

Reset
REQ-026 While rst=1, asynchronously: state=HOLD, hold counter=0, core_rst=1, running=0, done=0, pass=0, timeout=0, exit_code=0, cycle_cnt=0, retire_cnt=0.
REQ-027 rst asserted mid-RUN or in DONE SHALL abort immediately to the REQ-026 values; a full RST_CYCLES hold SHALL follow the release.

Verification
REQ-028 Release rst; count cycles -> core_rst high for exactly 4 cycles, then running=1 and cycle_cnt=0 on the first RUN cycle.
REQ-029 10 retires, then a store of 1 to 32'h1000 at RUN cycle 20 -> done=1, pass=1, exit_code=1, retire_cnt=10, cycle_cnt=20 frozen.
REQ-030 Store of 32'h7 to TOHOST_ADDR and an ECALL retire in the same cycle -> pass=0, exit_code=7, timeout=0.
REQ-031 No halt, TIMEOUT=250 -> done on RUN cycle 249, timeout=1, pass=0, exit_code=FFFF_FFFF; with ECALL_HALT=0 an ECALL does not halt.
REQ-032 rst pulse at RUN cycle 50 -> all outputs return to reset values at once, then a 4-cycle hold, then RUN again from 0.
REQ-033 restart in DONE -> counters cleared, 4-cycle hold, new RUN; restart pulsed during RUN -> no effect.
